// File: rtl/pc_pkg.sv
// Shared definitions for the 16-bit program counter chip:
// word width, reset vector, word type and the decoded command set.
package pc_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_VECTOR = 16'h0000;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_LOAD,
    PC_CALL,
    PC_RET,
    PC_SWAP
  } pc_cmd_e;

  // Priority decode: call+ret, ret, call, load, inc, hold.
  // call+ret on an empty stack has nothing to replace, so it degrades to a call.
  function automatic pc_cmd_e decode_cmd(input logic call, input logic ret,
                                         input logic load, input logic inc,
                                         input logic empty);
    pc_cmd_e cmd;
    if (call && ret)  cmd = empty ? PC_CALL : PC_SWAP;
    else if (ret)     cmd = PC_RET;
    else if (call)    cmd = PC_CALL;
    else if (load)    cmd = PC_LOAD;
    else if (inc)     cmd = PC_INC;
    else              cmd = PC_HOLD;
    return cmd;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: push, pop and replace-top, with occupancy count
// and full/empty status. The caller never pushes when full or pops /
// replaces when empty; those cases are resolved in the program counter.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     replace,
  input  word_t                    wdata,
  output word_t                    rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  word_t           mem [DEPTH];
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   top_pos;

  assign top_pos = count_reg - CW'(1);
  assign count   = count_reg;
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  // Top-of-stack is read directly so a return completes in one cycle.
  assign rdata   = mem[top_pos[AW-1:0]];

  // Entry storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push)
      mem[count_reg[AW-1:0]] <= wdata;
    else if (replace)
      mem[top_pos[AW-1:0]] <= wdata;
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_reg <= '0;
    else if (push && !pop)
      count_reg <= count_reg + CW'(1);
    else if (pop && !push)
      count_reg <= count_reg - CW'(1);
  end

endmodule

// File: rtl/pc_16bit_chip.sv
// 16-bit program counter with integrated return-address stack.
// Optional build macro PC_WRAP_FLAG_EN adds a sticky `wrap` output that
// records the counter wrapping from 0xFFFF to 0x0000.
module pc_16bit_chip
  import pc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [WORD_W-1:0]        out,
  input  logic [WORD_W-1:0]        in,
  input  logic                     load,
  input  logic                     inc,
  input  logic                     call,
  input  logic                     ret,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     ovf,
  output logic                     unf
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic                     wrap
`endif
);

  pc_cmd_e cmd;
  word_t   out_plus1;
  word_t   out_next;
  word_t   stack_top;
  logic    push, pop, replace;
  logic    full, empty;
  logic    ovf_next, unf_next;

  // Return address is always the pre-call out+1, wrapping naturally.
  assign out_plus1 = out + word_t'(1);

  // Resolve the simultaneous command inputs into one operation.
  always_comb begin
    cmd = decode_cmd(call, ret, load, inc, empty);
  end

  // Next-state and stack controls for the decoded operation.
  always_comb begin
    out_next = out;
    push     = 1'b0;
    pop      = 1'b0;
    replace  = 1'b0;
    ovf_next = ovf;
    unf_next = unf;
    case (cmd)
      PC_INC:  out_next = out_plus1;
      PC_LOAD: out_next = in;
      PC_CALL: begin
        out_next = in;
        if (full) ovf_next = 1'b1;
        else      push     = 1'b1;
      end
      PC_RET: begin
        if (empty) begin
          unf_next = 1'b1;
        end else begin
          out_next = stack_top;
          pop      = 1'b1;
        end
      end
      PC_SWAP: begin
        out_next = in;
        replace  = 1'b1;
      end
      default: ;
    endcase
  end

  // Program counter and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= RESET_VECTOR;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      out <= out_next;
      ovf <= ovf_next;
      unf <= unf_next;
    end
  end

`ifdef PC_WRAP_FLAG_EN
  logic wrap_next;

  // Wrap occurs on inc from 0xFFFF or when a return address is stored from 0xFFFF.
  always_comb begin
    wrap_next = wrap;
    if ((out == 16'hFFFF) &&
        ((cmd == PC_INC) || (cmd == PC_SWAP) || ((cmd == PC_CALL) && !full)))
      wrap_next = 1'b1;
  end

  // Sticky wrap flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= wrap_next;
  end
`endif

  pc_ret_stack #(.DEPTH(DEPTH)) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .replace (replace),
    .wdata   (out_plus1),
    .rdata   (stack_top),
    .count   (depth),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_pc_16bit_chip.sv
// Self-checking bench for pc_16bit_chip: directed scenarios followed by
// randomized commands, compared against a queue-based reference model.
module tb_pc_16bit_chip;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   out;
  logic [15:0]   in;
  logic          load, inc, call, ret;
  logic [CW-1:0] depth;
  logic          ovf, unf;
`ifdef PC_WRAP_FLAG_EN
  logic          wrap;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [15:0] m_out;
  bit          m_ovf, m_unf, m_wrap;
  logic [15:0] m_stk[$];

  always #5 clk = ~clk;

  pc_16bit_chip #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .out   (out),
    .in    (in),
    .load  (load),
    .inc   (inc),
    .call  (call),
    .ret   (ret),
    .depth (depth),
    .ovf   (ovf),
    .unf   (unf)
`ifdef PC_WRAP_FLAG_EN
    ,
    .wrap  (wrap)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".out"},   32'(out),   32'(m_out));
    check({ctx, ".depth"}, 32'(depth), 32'(m_stk.size()));
    check({ctx, ".ovf"},   32'(ovf),   32'(m_ovf));
    check({ctx, ".unf"},   32'(unf),   32'(m_unf));
`ifdef PC_WRAP_FLAG_EN
    check({ctx, ".wrap"},  32'(wrap),  32'(m_wrap));
`endif
  endtask

  task automatic model_reset();
    m_out = 16'h0000;
    m_ovf = 0;
    m_unf = 0;
    m_wrap = 0;
    m_stk.delete();
  endtask

  // Behavioural rules: call+ret swap, ret, call, load, inc, hold.
  task automatic model_step(input bit c, input bit r, input bit l, input bit i, input logic [15:0] d);
    logic [15:0] ra;
    ra = m_out + 16'd1;
    if (c && r && m_stk.size() > 0) begin
      m_stk[m_stk.size()-1] = ra;
      if (m_out == 16'hFFFF) m_wrap = 1;
      m_out = d;
    end else if (r && !c) begin
      if (m_stk.size() > 0) m_out = m_stk.pop_back();
      else                  m_unf = 1;
    end else if (c) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(ra);
        if (m_out == 16'hFFFF) m_wrap = 1;
      end else begin
        m_ovf = 1;
      end
      m_out = d;
    end else if (l) begin
      m_out = d;
    end else if (i) begin
      if (m_out == 16'hFFFF) m_wrap = 1;
      m_out = ra;
    end
  endtask

  task automatic cycle(input bit c, input bit r, input bit l, input bit i,
                       input logic [15:0] d, input string ctx);
    call = c; ret = r; load = l; inc = i; in = d;
    @(posedge clk);
    #1;
    model_step(c, r, l, i, d);
    $display("%s: call=%0b ret=%0b load=%0b inc=%0b in=%04h -> out=%04h depth=%0d ovf=%0b unf=%0b",
             ctx, c, r, l, i, d, out, depth, ovf, unf);
    check_all(ctx);
    call = 0; ret = 0; load = 0; inc = 0;
  endtask

  task automatic do_reset(input string ctx);
    reset = 1'b1;
    #1;
    model_reset();
    check_all({ctx, ".async"});
    @(posedge clk);
    #2;
    reset = 1'b0;
    check_all({ctx, ".held"});
  endtask

  initial begin
    reset = 0; load = 0; inc = 0; call = 0; ret = 0; in = 16'h0000;
    model_reset();
    #2;

    do_reset("rst0");

    // Increment from reset
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 16'h0000, "inc");

    // Reset between edges takes effect before the next clock
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    #2;
    reset = 1'b0;

    // Load beats inc, then inc
    cycle(0, 0, 1, 1, 16'h1234, "load_inc");
    cycle(0, 0, 0, 1, 16'h0000, "inc2");

    // Simple call / ret
    cycle(0, 0, 1, 0, 16'h0010, "load10");
    cycle(1, 0, 1, 1, 16'h0200, "call1");
    cycle(0, 1, 0, 0, 16'hBEEF, "ret1");

    // Nested calls through overflow, then returns through underflow
    for (int k = 0; k < DEPTH + 1; k++)
      cycle(1, 0, 0, 0, (k == DEPTH) ? 16'h0ABC : 16'(16'h0100 + k * 16'h0011), "ncall");
    for (int k = 0; k < DEPTH + 1; k++)
      cycle(0, 1, 0, 1, 16'h5555, "nret");

    // Tail-call swap
    do_reset("rst1");
    cycle(0, 0, 1, 0, 16'h0004, "load04");
    cycle(1, 0, 0, 0, 16'h0020, "call20");
    cycle(1, 1, 0, 0, 16'h0300, "swap");
    cycle(0, 1, 0, 0, 16'h0000, "ret_swap");
    cycle(1, 1, 0, 0, 16'h0400, "swap_empty");
    cycle(0, 1, 0, 0, 16'h0000, "ret_se");

    // Wrap-around on inc and on call
    cycle(0, 0, 1, 0, 16'hFFFF, "loadFFFF");
    cycle(0, 0, 0, 1, 16'h0000, "wrapinc");
    cycle(0, 0, 1, 0, 16'hFFFF, "loadFFFF2");
    cycle(1, 0, 0, 0, 16'h0010, "callFFFF");
    cycle(0, 1, 0, 0, 16'h0000, "retFFFF");

    // Randomized commands with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset("rrst");
      end else begin
        cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
              16'($urandom), "rand");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
